toast_if_stage: RTL and testbench

Instruction fetch stage of the Toast RV32I 5-stage pipeline. It sits directly upstream of the decode stage.
- Owns the program counter and drives a synchronous-read instruction memory (1-cycle read latency).
- Registers {pc, instruction} into the IF/ID pipeline register consumed by decode.
- Handles stall, flush and EX-stage branch/jump redirects, inserting NOP bubbles on squashed slots.

---
 rtl/toast_if_stage.sv | 120 ++++++++++++
 tb/tb_toast_if_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/toast_if_stage.sv
// Instruction fetch stage of the Toast RV32I pipeline: owns the PC, drives a 1-cycle
// synchronous instruction memory and loads the IF/ID register with {pc, instruction, valid}.
module toast_if_stage #(
    parameter int unsigned                REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0]  RESET_PC       = 32'h0000_0000,
    parameter logic [REG_DATA_WIDTH-1:0]  NOP_INSTR      = 32'h0000_0013
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      EX_branch_en_i,
    input  logic [REG_DATA_WIDTH-1:0] EX_branch_dest_i,
    output logic [REG_DATA_WIDTH-1:0] imem_addr_o,
    output logic                      imem_rd_en_o,
    input  logic [REG_DATA_WIDTH-1:0] imem_data_i,
    output logic [REG_DATA_WIDTH-1:0] IF_pc_o,
    output logic [REG_DATA_WIDTH-1:0] IF_instruction_o,
    output logic                      IF_valid_o
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    localparam logic [REG_DATA_WIDTH-1:0] PcStep    = REG_DATA_WIDTH'(4);
    localparam logic [REG_DATA_WIDTH-1:0] AlignMask = ~REG_DATA_WIDTH'(3);

    state_e                    state_q, state_d;
    logic [REG_DATA_WIDTH-1:0] pc_q, pc_d;
    logic                      data_valid_q, data_valid_d;
    logic [REG_DATA_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [REG_DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic                      if_valid_q, if_valid_d;
    logic [REG_DATA_WIDTH-1:0] pc_plus4;

    assign pc_plus4 = pc_q + PcStep;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        data_valid_d = data_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_valid_d   = if_valid_q;
        imem_addr_o  = RESET_PC;
        imem_rd_en_o = 1'b0;

        if (!reset_i) begin
            imem_rd_en_o = 1'b1;
            unique case (state_q)
                StBoot: begin
                    imem_addr_o  = RESET_PC;
                    pc_d         = RESET_PC;
                    data_valid_d = 1'b1;
                    if_pc_d      = '0;
                    if_instr_d   = NOP_INSTR;
                    if_valid_d   = 1'b0;
                    state_d      = StRun;
                end
                StRun: begin
                    if (EX_branch_en_i) begin
                        // Wrong-path word on imem_data_i is dropped by loading a bubble.
                        imem_addr_o  = EX_branch_dest_i & AlignMask;
                        pc_d         = imem_addr_o;
                        data_valid_d = 1'b1;
                        if_pc_d      = '0;
                        if_instr_d   = NOP_INSTR;
                        if_valid_d   = 1'b0;
                    end else if (flush_i) begin
                        imem_addr_o  = pc_plus4;
                        pc_d         = pc_plus4;
                        data_valid_d = 1'b1;
                        if_pc_d      = '0;
                        if_instr_d   = NOP_INSTR;
                        if_valid_d   = 1'b0;
                    end else if (stall_i) begin
                        // Re-issue the same address so its data is presented again next cycle.
                        imem_addr_o  = pc_q;
                    end else begin
                        imem_addr_o  = pc_plus4;
                        pc_d         = pc_plus4;
                        data_valid_d = 1'b1;
                        if (data_valid_q) begin
                            if_pc_d    = pc_q;
                            if_instr_d = imem_data_i;
                            if_valid_d = 1'b1;
                        end else begin
                            if_pc_d    = '0;
                            if_instr_d = NOP_INSTR;
                            if_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = StBoot;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            data_valid_q <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            data_valid_q <= data_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
        end
    end

    assign IF_pc_o          = if_pc_q;
    assign IF_instruction_o = if_instr_q;
    assign IF_valid_o       = if_valid_q;

endmodule

// File: tb/tb_toast_if_stage.sv
// Directed bench for toast_if_stage; the instruction memory returns addr | 0x100.
module tb_toast_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        br_en;
    logic [31:0] br_dest;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    int checks = 0;
    int errors = 0;

    toast_if_stage dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .stall_i          (stall),
        .flush_i          (flush),
        .EX_branch_en_i   (br_en),
        .EX_branch_dest_i (br_dest),
        .imem_addr_o      (imem_addr),
        .imem_rd_en_o     (imem_rd_en),
        .imem_data_i      (imem_data),
        .IF_pc_o          (if_pc),
        .IF_instruction_o (if_instr),
        .IF_valid_o       (if_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= imem_addr | 32'h100;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic vld);
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".instr"}, if_instr, instr);
        check({tag, ".valid"}, {31'b0, if_valid}, {31'b0, vld});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; br_en = 1'b0; br_dest = 32'h0;
        tick(); tick();
        check_if("reset", 32'h0, 32'h13, 1'b0);
        check("reset.rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("reset.addr", imem_addr, 32'h0);

        // Boot cycle; a branch here must be ignored.
        reset = 1'b0; br_en = 1'b1; br_dest = 32'h200; #1;
        check("boot.addr", imem_addr, 32'h0);
        check("boot.rd_en", {31'b0, imem_rd_en}, 32'h1);
        tick(); br_en = 1'b0; #1;
        check_if("boot", 32'h0, 32'h13, 1'b0);
        check("run0.addr", imem_addr, 32'h4);
        tick(); check_if("seq0", 32'h0, 32'h100, 1'b1);
        tick(); check_if("seq4", 32'h4, 32'h104, 1'b1);
        tick(); check_if("seq8", 32'h8, 32'h108, 1'b1);

        // Stall for three cycles.
        stall = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            check("stall.addr", imem_addr, 32'hC);
            tick();
            check_if("stall", 32'h8, 32'h108, 1'b1);
        end
        stall = 1'b0;
        tick(); check_if("unstallC", 32'hC, 32'h10C, 1'b1);
        tick(); check_if("unstall10", 32'h10, 32'h110, 1'b1);

        // Redirect to 0x40 while pc_q = 0x14.
        br_en = 1'b1; br_dest = 32'h40; #1;
        check("br.addr", imem_addr, 32'h40);
        tick(); br_en = 1'b0;
        check_if("br.bubble", 32'h0, 32'h13, 1'b0);
        tick(); check_if("br40", 32'h40, 32'h140, 1'b1);
        tick(); check_if("br44", 32'h44, 32'h144, 1'b1);

        // Misaligned redirect with simultaneous stall: branch wins.
        br_en = 1'b1; br_dest = 32'h43; stall = 1'b1; #1;
        check("brstall.addr", imem_addr, 32'h40);
        tick(); br_en = 1'b0; stall = 1'b0;
        check_if("brstall.bubble", 32'h0, 32'h13, 1'b0);
        tick(); check_if("brstall40", 32'h40, 32'h140, 1'b1);

        // Move pc_q to 0x20, then flush one cycle.
        br_en = 1'b1; br_dest = 32'h20; tick(); br_en = 1'b0;
        flush = 1'b1; #1;
        check("flush.addr", imem_addr, 32'h24);
        tick(); flush = 1'b0;
        check_if("flush.bubble", 32'h0, 32'h13, 1'b0);
        tick(); check_if("flush24", 32'h24, 32'h124, 1'b1);

        // PC wrap at the top of the address space.
        br_en = 1'b1; br_dest = 32'hFFFF_FFFC; tick(); br_en = 1'b0;
        tick(); check_if("wrapTop", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        check("wrap.addr", imem_addr, 32'h4);
        tick(); check_if("wrap0", 32'h0, 32'h100, 1'b1);

        // Mid-stream reset at pc_q = 0x80.
        br_en = 1'b1; br_dest = 32'h80; tick(); br_en = 1'b0;
        tick(); check_if("pre_rst", 32'h80, 32'h180, 1'b1);
        reset = 1'b1; #1;
        check("rst.rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("rst.addr", imem_addr, 32'h0);
        tick();
        check_if("rst", 32'h0, 32'h13, 1'b0);
        check("rst.rd_en2", {31'b0, imem_rd_en}, 32'h0);
        reset = 1'b0; #1;
        check("reboot.addr", imem_addr, 32'h0);
        check("reboot.rd_en", {31'b0, imem_rd_en}, 32'h1);
        tick(); check_if("reboot", 32'h0, 32'h13, 1'b0);
        tick(); check_if("reboot0", 32'h0, 32'h100, 1'b1);
        tick(); check_if("reboot4", 32'h4, 32'h104, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
